// File: rtl/program_counter.sv
// Instruction-address register with a small RUN/DELAY/HALT sequencer.
// Interruption freezes all state; reset is asynchronous and wins over everything.
module program_counter #(
   parameter int                 ADDR_W   = 10,
   parameter int                 DELAY_W  = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                interruption_i,
   input  logic [1:0]          flagPC_i,
   input  logic                flagJR_i,
   input  logic [ADDR_W-1:0]   immAddr_i,
   input  logic [31:0]         regAddr_i,
   input  logic [DELAY_W-1:0]  delayCycles_i,
   output logic [ADDR_W-1:0]   pc_o,
   output logic                busy_o,
   output logic                halted_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DELAY = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [1:0]         FLAG_HOLD  = 2'd0;
   localparam logic [1:0]         FLAG_INC   = 2'd1;
   localparam logic [1:0]         FLAG_JUMP  = 2'd2;
   localparam logic [1:0]         FLAG_DELAY = 2'd3;
   localparam logic [ADDR_W-1:0]  PC_ONE     = ADDR_W'(1);
   localparam logic [DELAY_W-1:0] CNT_ONE    = DELAY_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DELAY_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]   jump_target;

   // Only the low ADDR_W bits of the register operand address instruction memory.
   assign jump_target = flagJR_i ? regAddr_i[ADDR_W-1:0] : immAddr_i;

   generate
      if (ADDR_W < 32) begin : g_reg_unused
         logic unused_reg_bits;
         assign unused_reg_bits = ^regAddr_i[31:ADDR_W];
      end
   endgenerate

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (!interruption_i) begin
         unique case (state_q)
            ST_RUN: begin
               unique case (flagPC_i)
                  FLAG_HOLD: state_d = ST_HALT;
                  FLAG_INC:  pc_d = pc_q + PC_ONE;
                  FLAG_JUMP: pc_d = jump_target;
                  FLAG_DELAY: begin
                     if (delayCycles_i == '0) begin
                        pc_d = pc_q + PC_ONE;
                     end else begin
                        cnt_d   = delayCycles_i;
                        state_d = ST_DELAY;
                     end
                  end
                  default: state_d = state_q;
               endcase
            end
            ST_DELAY: begin
               // Treating a count of 0 as "done" keeps the counter from ever wrapping.
               if (cnt_q > CNT_ONE) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  cnt_d   = '0;
                  pc_d    = pc_q + PC_ONE;
                  state_d = ST_RUN;
               end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign pc_o     = pc_q;
   assign busy_o   = (state_q == ST_DELAY);
   assign halted_o = (state_q == ST_HALT);

endmodule

// File: tb/tb_program_counter.sv
// Scenario bench for program_counter: expected pc/busy/halted go into a queue
// as each cycle is driven and are popped and compared once the edge has passed.
module tb_program_counter;

   typedef struct packed {
      logic [1:0]  flag;
      logic        jr;
      logic [9:0]  imm;
      logic [31:0] rg;
      logic [15:0] dly;
      logic        intr;
      logic [9:0]  epc;
      logic        ebusy;
      logic        ehalt;
   } stim_t;

   typedef struct packed {
      logic [9:0] pc;
      logic       busy;
      logic       halted;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        interruption;
   logic [1:0]  flagPC;
   logic        flagJR;
   logic [9:0]  immAddr;
   logic [31:0] regAddr;
   logic [15:0] delayCycles;
   logic [9:0]  pc;
   logic        busy;
   logic        halted;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   program_counter #(.ADDR_W(10), .DELAY_W(16), .RESET_PC(10'd0)) dut (
      .clock_i        (clock),
      .reset_i        (reset),
      .interruption_i (interruption),
      .flagPC_i       (flagPC),
      .flagJR_i       (flagJR),
      .immAddr_i      (immAddr),
      .regAddr_i      (regAddr),
      .delayCycles_i  (delayCycles),
      .pc_o           (pc),
      .busy_o         (busy),
      .halted_o       (halted)
   );

   always #5 clock = ~clock;

   function automatic stim_t mk(input logic [1:0] f, input logic jr, input logic [9:0] imm,
                                input logic [31:0] rg, input logic [15:0] d, input logic it,
                                input logic [9:0] epc, input logic eb, input logic eh);
      stim_t s;
      s.flag = f; s.jr = jr; s.imm = imm; s.rg = rg; s.dly = d; s.intr = it;
      s.epc = epc; s.ebusy = eb; s.ehalt = eh;
      return s;
   endfunction

   // Drive one cycle's inputs, queue its expectation, and land 1 time unit past the edge.
   task automatic apply(input stim_t s);
      exp_t e;
      flagPC = s.flag; flagJR = s.jr; immAddr = s.imm; regAddr = s.rg;
      delayCycles = s.dly; interruption = s.intr;
      e.pc = s.epc; e.busy = s.ebusy; e.halted = s.ehalt;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1; interruption = 1'b0; flagPC = 2'd1; flagJR = 1'b0;
      immAddr = '0; regAddr = '0; delayCycles = '0;
      #2;
      e.pc = 10'd0; e.busy = 1'b0; e.halted = 1'b0;
      exp_q.push_back(e);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
         n_fail++;
         $display("FAIL reset_async: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                  pc, busy, halted, e.pc, e.busy, e.halted);
      end else $display("reset_async pc=%0d busy=%0b halted=%0b", pc, busy, halted);
      // flagPC=1 while reset is held must not move pc.
      apply(mk(2'd1, 0, 0, 0, 0, 0, 10'd0, 0, 0));
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
         n_fail++;
         $display("FAIL reset_held: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                  pc, busy, halted, e.pc, e.busy, e.halted);
      end else $display("reset_held pc=%0d busy=%0b halted=%0b", pc, busy, halted);
      reset = 1'b0;
   endtask

   task automatic test_increment();
      stim_t t[3];
      exp_t  e;
      t[0] = mk(2'd1, 0, 0, 0, 0, 0, 10'd1, 0, 0);
      t[1] = mk(2'd1, 0, 0, 0, 0, 0, 10'd2, 0, 0);
      t[2] = mk(2'd1, 0, 0, 0, 0, 0, 10'd3, 0, 0);
      foreach (t[i]) begin
         apply(t[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL increment[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("increment[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
   endtask

   task automatic test_jump();
      stim_t t[4];
      exp_t  e;
      t[0] = mk(2'd1, 0, 0, 0, 0, 0, 10'd4, 0, 0);
      t[1] = mk(2'd1, 0, 0, 0, 0, 0, 10'd5, 0, 0);
      t[2] = mk(2'd2, 0, 10'd40, 32'h0000_0C07, 0, 0, 10'd40, 0, 0);
      t[3] = mk(2'd2, 1, 10'd40, 32'h0000_0C07, 0, 0, 10'd7, 0, 0);
      foreach (t[i]) begin
         apply(t[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL jump[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("jump[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
   endtask

   task automatic test_delay();
      stim_t t[6];
      exp_t  e;
      t[0] = mk(2'd2, 0, 10'd9, 0, 0, 0, 10'd9, 0, 0);
      t[1] = mk(2'd3, 0, 0, 0, 16'd3, 0, 10'd9, 1, 0);
      // Jump/halt requests and a new delay length while delaying must be ignored.
      t[2] = mk(2'd2, 0, 10'd100, 0, 16'd7, 0, 10'd9, 1, 0);
      t[3] = mk(2'd0, 1, 10'd100, 32'h55, 16'd7, 0, 10'd9, 1, 0);
      t[4] = mk(2'd3, 0, 10'd100, 0, 16'd7, 0, 10'd10, 0, 0);
      t[5] = mk(2'd3, 0, 0, 0, 16'd0, 0, 10'd11, 0, 0);
      foreach (t[i]) begin
         apply(t[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL delay[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("delay[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
   endtask

   task automatic test_wrap_interrupt();
      stim_t t[9];
      exp_t  e;
      t[0] = mk(2'd2, 0, 10'd1023, 0, 0, 0, 10'd1023, 0, 0);
      t[1] = mk(2'd1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
      t[2] = mk(2'd1, 0, 0, 0, 0, 1, 10'd0, 0, 0);
      t[3] = mk(2'd3, 0, 0, 0, 16'd2, 0, 10'd0, 1, 0);
      t[4] = mk(2'd1, 0, 0, 0, 0, 1, 10'd0, 1, 0);
      t[5] = mk(2'd2, 0, 10'd77, 0, 0, 1, 10'd0, 1, 0);
      t[6] = mk(2'd1, 0, 0, 0, 0, 0, 10'd0, 1, 0);
      t[7] = mk(2'd1, 0, 0, 0, 0, 0, 10'd1, 0, 0);
      t[8] = mk(2'd0, 0, 0, 0, 0, 1, 10'd1, 0, 0);
      foreach (t[i]) begin
         apply(t[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL wrap_intr[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("wrap_intr[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
   endtask

   task automatic test_halt();
      stim_t t[8];
      exp_t  e;
      t[0] = mk(2'd0, 0, 0, 0, 0, 0, 10'd1, 0, 1);
      for (int k = 1; k <= 5; k++) t[k] = mk(2'd1, 0, 0, 0, 0, 0, 10'd1, 0, 1);
      t[6] = mk(2'd2, 0, 10'd300, 0, 0, 0, 10'd1, 0, 1);
      t[7] = mk(2'd3, 0, 0, 0, 16'd4, 0, 10'd1, 0, 1);
      foreach (t[i]) begin
         apply(t[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL halt[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("halt[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
      // Reset pulse well clear of any clock edge.
      reset = 1'b1;
      #1;
      e.pc = 10'd0; e.busy = 1'b0; e.halted = 1'b0;
      exp_q.push_back(e);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
         n_fail++;
         $display("FAIL halt_reset: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                  pc, busy, halted, e.pc, e.busy, e.halted);
      end else $display("halt_reset pc=%0d busy=%0b halted=%0b", pc, busy, halted);
      #1 reset = 1'b0;
      apply(mk(2'd1, 0, 0, 0, 0, 0, 10'd1, 0, 0));
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
         n_fail++;
         $display("FAIL halt_release: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                  pc, busy, halted, e.pc, e.busy, e.halted);
      end else $display("halt_release pc=%0d busy=%0b halted=%0b", pc, busy, halted);
   endtask

   task automatic test_delay_reset();
      stim_t t[2];
      stim_t r[3];
      exp_t  e;
      t[0] = mk(2'd3, 0, 0, 0, 16'd3, 0, 10'd1, 1, 0);
      t[1] = mk(2'd1, 0, 0, 0, 0, 0, 10'd1, 1, 0);
      foreach (t[i]) begin
         apply(t[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL dreset_pre[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("dreset_pre[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
      reset = 1'b1;
      #1;
      e.pc = 10'd0; e.busy = 1'b0; e.halted = 1'b0;
      exp_q.push_back(e);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
         n_fail++;
         $display("FAIL dreset_now: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                  pc, busy, halted, e.pc, e.busy, e.halted);
      end else $display("dreset_now pc=%0d busy=%0b halted=%0b", pc, busy, halted);
      #1 reset = 1'b0;
      // A leftover count would show up as busy or a missed/extra increment here.
      r[0] = mk(2'd1, 0, 0, 0, 0, 0, 10'd1, 0, 0);
      r[1] = mk(2'd1, 0, 0, 0, 0, 0, 10'd2, 0, 0);
      r[2] = mk(2'd0, 0, 0, 0, 0, 0, 10'd2, 0, 1);
      foreach (r[i]) begin
         apply(r[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (pc !== e.pc || busy !== e.busy || halted !== e.halted) begin
            n_fail++;
            $display("FAIL dreset_post[%0d]: got pc=%0d busy=%0b halted=%0b, want pc=%0d busy=%0b halted=%0b",
                     i, pc, busy, halted, e.pc, e.busy, e.halted);
         end else $display("dreset_post[%0d] pc=%0d busy=%0b halted=%0b", i, pc, busy, halted);
      end
   endtask

   initial begin
      test_reset();
      test_increment();
      test_jump();
      test_delay();
      test_wrap_interrupt();
      test_halt();
      test_delay_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
